// File: rtl/sia_txq.sv
// SIA transmit queue: FIFO of software-built frames serialised LSB-first on TXD with optional bit clock on TXC.
// First bit appears one edge after the word reaches an idle engine; pushes while full are dropped.
module sia_txq #(
  parameter int SHIFT_REG_WIDTH = 16,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int BITS_WIDTH      = 5,
  parameter int DEPTH_BITS      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [BITS_WIDTH-1:0]      bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       txcpol_i,
  input  logic                       txq_we_i,
  input  logic [SHIFT_REG_WIDTH-1:0] txq_dat_i,
  output logic                       txq_full_o,
  output logic                       txq_empty_o,
  output logic                       idle_o,
  output logic                       txd_o,
  output logic                       txc_o
);
  localparam int SRW = SHIFT_REG_WIDTH - 1;
  localparam int BRW = BAUD_RATE_WIDTH - 1;
  localparam int BW  = BITS_WIDTH - 1;
  localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(2**DEPTH_BITS);
  localparam logic [DEPTH_BITS:0] CNT_ONE = (DEPTH_BITS+1)'(1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [SRW:0]            mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]     count, count_nxt;
  logic                    push, pop;

  state_t                  state;
  logic [SRW:0]            shreg;
  logic [BW:0]             bits_l, bit_cnt;
  logic [BRW:0]            baud_l, baud_cnt;
  logic                    txd, idle;
  logic                    bit_end, word_end;

  assign push     = txq_we_i && !txq_full_o;
  assign bit_end  = (baud_cnt == baud_l);
  assign word_end = bit_end && (bit_cnt == bits_l - BITS_WIDTH'(1));
  // A new word is taken whenever the engine is free or finishing its last bit.
  assign pop      = !txq_empty_o && ((state == IDLE) || word_end);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= txq_dat_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      txq_full_o  <= 1'b0;
      txq_empty_o <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      count       <= count_nxt;
      txq_full_o  <= (count_nxt == DEPTH_C);
      txq_empty_o <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      shreg    <= '0;
      bits_l   <= '0;
      baud_l   <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
      idle     <= 1'b1;
    end else if (pop) begin
      shreg    <= mem[rd_ptr];
      bits_l   <= bits_i;
      baud_l   <= baud_i;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      // A zero-length word is consumed without ever leaving mark.
      if (bits_i == '0) begin
        state <= IDLE;
        txd   <= 1'b1;
        idle  <= 1'b1;
      end else begin
        state <= SEND;
        txd   <= mem[rd_ptr][0];
        idle  <= 1'b0;
      end
    end else if (state == SEND) begin
      if (word_end) begin
        state    <= IDLE;
        baud_cnt <= '0;
        txd      <= 1'b1;
        idle     <= 1'b1;
      end else if (bit_end) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + BITS_WIDTH'(1);
        shreg    <= {1'b1, shreg[SRW:1]};
        txd      <= shreg[1];
      end else begin
        baud_cnt <= baud_cnt + BAUD_RATE_WIDTH'(1);
      end
    end
  end

  assign txd_o  = txd;
  assign idle_o = idle;
  assign txc_o  = ((state == SEND) && (baud_cnt > (baud_l >> 1))) ^ txcpol_i;
endmodule

// File: tb/tb_sia_txq.sv
// Directed bench for sia_txq: per-clock expected (txd, txc) pairs are queued at push time and consumed while the line is busy.
module tb_sia_txq;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  bits;
  logic [31:0] baud;
  logic        txcpol;
  logic        we;
  logic [15:0] dat;
  logic        full, empty, idle, txd, txc;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] e;

  sia_txq dut (
    .clk_i(clk), .reset_i(rst), .bits_i(bits), .baud_i(baud), .txcpol_i(txcpol),
    .txq_we_i(we), .txq_dat_i(dat), .txq_full_o(full), .txq_empty_o(empty),
    .idle_o(idle), .txd_o(txd), .txc_o(txc)
  );

  always #5 clk = ~clk;

  // Every busy clock must match the next queued {txd, txc_o} pair.
  always @(negedge clk) begin
    if (!rst && !idle) begin
      checks++;
      if (exp_q.size() == 0) begin
        assert (0) else begin
          errors++;
          $error("FAIL serial_extra: txd=%0b txc=%0b with nothing expected", txd, txc);
        end
      end else begin
        e = exp_q.pop_front();
        assert ({txd, txc} === e) else begin
          errors++;
          $error("FAIL serial: {txd,txc} got %b expected %b", {txd, txc}, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_word(input logic [15:0] w, input int nbits, input int nbaud, input logic pol);
    logic b, c;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j <= nbaud; j++) begin
        b = (i < 16) ? w[i] : 1'b1;
        c = (j > nbaud / 2) ^ pol;
        exp_q.push_back({b, c});
      end
    end
  endtask

  task automatic push(input logic [15:0] w);
    dat = w;
    we  = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  // Counts negedges waited before the line goes busy, then negedges it stays busy.
  task automatic measure_busy(input string tag, input int exp_len, output int waited);
    int n = 0;
    waited = 0;
    @(negedge clk);
    while (idle === 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    while (idle === 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_len);
  endtask

  task automatic wait_idle(input string tag);
    int w = 0;
    @(negedge clk);
    while (idle !== 1'b1 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_idle"}, idle, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int w;
    logic stuck;
    rst = 1'b1; bits = 5'd10; baud = 32'd3; txcpol = 1'b0; we = 1'b0; dat = '0;
    #2;
    check("reset_txd", txd, 1);
    check("reset_idle", idle, 1);
    check("reset_empty", empty, 1);
    check("reset_full", full, 0);
    check("reset_txc", txc, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 0x0155, 10 bits, 4 clocks per bit
    add_word(16'h0155, 10, 3, 1'b0);
    push(16'h0155);
    measure_busy("frame_0155_len", 40, w);
    check("first_bit_latency", w, 1);
    check("frame_0155_drained", exp_q.size(), 0);

    // back-to-back words must leave no idle gap
    bits = 5'd2; baud = 32'd1;
    add_word(16'h0003, 2, 1, 1'b0);
    add_word(16'h0000, 2, 1, 1'b0);
    push(16'h0003);
    push(16'h0000);
    measure_busy("back_to_back_len", 8, w);
    check("back_to_back_drained", exp_q.size(), 0);

    // inverted bit clock
    bits = 5'd10; baud = 32'd3; txcpol = 1'b1;
    #1 check("txcpol_idle_txc", txc, 1);
    add_word(16'h0155, 10, 3, 1'b1);
    push(16'h0155);
    measure_busy("txcpol_len", 40, w);
    check("txcpol_after_txc", txc, 1);
    txcpol = 1'b0;

    // baud change in bit 2 only affects the next word
    add_word(16'h02AA, 10, 3, 1'b0);
    push(16'h02AA);
    repeat (9) @(posedge clk);
    #1 baud = 32'd7;
    add_word(16'h0333, 10, 7, 1'b0);
    push(16'h0333);
    wait_idle("baud_change");

    // first word moves straight to the shift register, so 17 words fit before full
    bits = 5'd6; baud = 32'd3;
    for (int k = 0; k < 18; k++) begin
      if (k < 17) add_word(16'h5A00 + 16'(k * 3), 6, 3, 1'b0);
      push(16'h5A00 + 16'(k * 3));
      if (k == 15) check("full_after_16", full, 0);
      if (k == 16) check("full_after_17", full, 1);
      if (k == 17) check("full_after_drop", full, 1);
    end
    wait_idle("fill");
    check("fill_empty", empty, 1);

    // zero-length word is consumed silently
    bits = 5'd0;
    push(16'h1234);
    repeat (3) @(negedge clk);
    check("bits0_empty", empty, 1);
    check("bits0_txd", txd, 1);
    check("bits0_idle", idle, 1);

    // more bits than the register: mark fill; baud 0 keeps txc low
    bits = 5'd18; baud = 32'd0;
    add_word(16'hA5C3, 18, 0, 1'b0);
    push(16'hA5C3);
    measure_busy("long_word_len", 18, w);
    check("long_word_drained", exp_q.size(), 0);

    // reset mid-frame abandons the frame and the queued word
    bits = 5'd10; baud = 32'd3;
    add_word(16'h0155, 10, 3, 1'b0);
    push(16'h0155);
    push(16'h0AAA);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_txd", txd, 1);
    check("midreset_idle", idle, 1);
    check("midreset_empty", empty, 1);
    @(posedge clk); #1 rst = 1'b0;
    stuck = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1 || idle !== 1'b1) stuck = 1'b1;
    end
    check("post_reset_quiet", stuck, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
